// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - shared types and constants for the Maple packet parser
package maple_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_CRC   = 2'd1,
    ST_SHORT = 2'd2,
    ST_LONG  = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK,
    S_TRAIL
  } state_t;

  // Field order matches the assembled little-endian word: len arrives first.
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] dest;
    logic [7:0] src;
    logic [7:0] len;
  } hdr_t;

endpackage

// File: rtl/maple_byte_packer.sv
// rtl/maple_byte_packer.sv - little-endian 4-byte to 32-bit word packer
module maple_byte_packer
  import maple_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        full
);

  localparam int CNT_W   = $clog2(HDR_BYTES);
  localparam int SHIFT_W = 8 * (HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HDR_BYTES - 1);

  logic [CNT_W-1:0]   count;
  logic [SHIFT_W-1:0] shift;

  // Newest byte enters at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      count <= count + CNT_W'(1);
      shift <= {byte_data, shift[SHIFT_W-1:8]};
    end
  end

  // The completed word is presented combinationally alongside the last byte.
  assign full = byte_valid && (count == LAST);
  assign word = {byte_data, shift};

endmodule

// File: rtl/maple_packet_parser.sv
// rtl/maple_packet_parser.sv - Maple bus packet parser: header decode, word packing, checksum
module maple_packet_parser
  import maple_pkg::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        data_ready,
  input  logic [7:0]  data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_cmd,
  output logic [7:0]  hdr_dest,
  output logic [7:0]  hdr_src,
  output logic [7:0]  hdr_len,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        pkt_done,
  output logic [1:0]  pkt_status
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      state, state_next, post_state;
  status_t     status, status_next, close_status;
  logic [7:0]  xor_acc, xor_next;
  logic [7:0]  word_cnt, word_cnt_next, word_cnt_inc;
  logic        pack_valid, pack_clear, pack_full;
  logic        hdr_done, word_done, close;
  logic [31:0] pack_word;
  hdr_t        hdr_in;

  assign pack_valid   = data_ready && (state == S_HEADER || state == S_PAYLOAD);
  assign pack_clear   = (state == S_IDLE);
  assign hdr_in       = hdr_t'(pack_word);
  assign hdr_done     = pack_full && (state == S_HEADER);
  assign word_done    = pack_full && (state == S_PAYLOAD);
  assign word_cnt_inc = word_cnt + 8'd1;
  assign close        = (state != S_IDLE) && !frame;

  maple_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (data),
    .word       (pack_word),
    .full       (pack_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // post_state is where this cycle's byte leaves us; closing is judged from there.
  always_comb begin
    post_state = state;
    if (data_ready) begin
      case (state)
        S_HEADER: begin
          if (hdr_done) begin
            if (hdr_in.len > MAX_LEN_B)  post_state = S_TRAIL;
            else if (hdr_in.len == 8'd0) post_state = S_CHECK;
            else                         post_state = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (word_done && word_cnt_inc == hdr_len) post_state = S_CHECK;
        S_CHECK:   post_state = S_TRAIL;
        default:   ;
      endcase
    end
    if (state == S_IDLE) state_next = frame ? S_HEADER : S_IDLE;
    else                 state_next = frame ? post_state : S_IDLE;
  end

  always_comb begin
    xor_next      = xor_acc;
    word_cnt_next = word_cnt;
    status_next   = status;
    if (state == S_IDLE) begin
      xor_next      = '0;
      word_cnt_next = '0;
      status_next   = ST_OK;
    end else if (data_ready) begin
      case (state)
        S_HEADER: begin
          xor_next = xor_acc ^ data;
          if (hdr_done && hdr_in.len > MAX_LEN_B) status_next = ST_LONG;
        end
        S_PAYLOAD: begin
          xor_next = xor_acc ^ data;
          if (word_done) word_cnt_next = word_cnt_inc;
        end
        S_CHECK:   if (data != xor_acc && status == ST_OK) status_next = ST_CRC;
        S_TRAIL:   status_next = ST_LONG;
        default:   ;
      endcase
    end
    close_status = status_next;
    if (status_next == ST_OK &&
        (post_state == S_HEADER || post_state == S_PAYLOAD || post_state == S_CHECK))
      close_status = ST_SHORT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xor_acc    <= '0;
      word_cnt   <= '0;
      status     <= ST_OK;
      hdr_valid  <= 1'b0;
      hdr_cmd    <= '0;
      hdr_dest   <= '0;
      hdr_src    <= '0;
      hdr_len    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      pkt_done   <= 1'b0;
      pkt_status <= '0;
    end else begin
      xor_acc    <= xor_next;
      word_cnt   <= word_cnt_next;
      status     <= status_next;
      hdr_valid  <= hdr_done;
      if (hdr_done) begin
        hdr_cmd  <= hdr_in.cmd;
        hdr_dest <= hdr_in.dest;
        hdr_src  <= hdr_in.src;
        hdr_len  <= hdr_in.len;
      end
      word_valid <= word_done;
      if (word_done) word <= pack_word;
      pkt_done   <= close;
      if (close) pkt_status <= close_status;
    end
  end

endmodule

// File: tb/tb_maple_packet_parser.sv
// tb/tb_maple_packet_parser.sv - directed self-checking bench for maple_packet_parser
module tb_maple_packet_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  data = 8'h00;

  logic        hdr_valid, word_valid, pkt_done;
  logic [7:0]  hdr_cmd, hdr_dest, hdr_src, hdr_len;
  logic [31:0] word;
  logic [1:0]  pkt_status;

  logic        hdr_valid_s, word_valid_s, pkt_done_s;
  logic [7:0]  hdr_cmd_s, hdr_dest_s, hdr_src_s, hdr_len_s;
  logic [31:0] word_s;
  logic [1:0]  pkt_status_s;

  int total = 0;
  int bad = 0;
  int n_word = 0;
  int n_done = 0;
  int n_word_s = 0;

  logic [7:0] pkt1 [8] = '{8'h01, 8'h00, 8'h20, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] pkt0 [4] = '{8'h00, 8'h00, 8'h20, 8'h01};

  maple_packet_parser dut (
    .clk(clk), .reset(reset), .frame(frame), .data_ready(data_ready), .data(data),
    .hdr_valid(hdr_valid), .hdr_cmd(hdr_cmd), .hdr_dest(hdr_dest), .hdr_src(hdr_src),
    .hdr_len(hdr_len), .word_valid(word_valid), .word(word), .pkt_done(pkt_done),
    .pkt_status(pkt_status)
  );

  maple_packet_parser #(.MAX_LEN(4)) dut_small (
    .clk(clk), .reset(reset), .frame(frame), .data_ready(data_ready), .data(data),
    .hdr_valid(hdr_valid_s), .hdr_cmd(hdr_cmd_s), .hdr_dest(hdr_dest_s), .hdr_src(hdr_src_s),
    .hdr_len(hdr_len_s), .word_valid(word_valid_s), .word(word_s), .pkt_done(pkt_done_s),
    .pkt_status(pkt_status_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid)   n_word++;
    if (pkt_done)     n_done++;
    if (word_valid_s) n_word_s++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic start_frame();
    frame = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    frame = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int w0, d0;

    reset = 1'b1;
    tick();
    tick();
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_status", pkt_status, 0);
    check("rst_word", word, 0);
    check("rst_hdr", {hdr_cmd, hdr_dest, hdr_src, hdr_len}, 0);
    reset = 1'b0;
    tick();

    // header-only packet
    w0 = n_word;
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(pkt0[i]);
    check("h0_hdr_valid", hdr_valid, 1);
    check("h0_fields", {hdr_cmd, hdr_dest, hdr_src, hdr_len}, 32'h01200000);
    send_byte(8'h21);
    check("h0_hdr_pulse", hdr_valid, 0);
    end_frame();
    check("h0_done", pkt_done, 1);
    check("h0_status", pkt_status, 0);
    check("h0_no_words", n_word - w0, 0);
    tick();
    check("h0_done_pulse", pkt_done, 0);

    // one-word packet, good checksum
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(pkt1[i]);
    check("w1_fields", {hdr_cmd, hdr_dest, hdr_src, hdr_len}, 32'h05200001);
    for (int i = 4; i < 7; i++) send_byte(pkt1[i]);
    check("w1_early", word_valid, 0);
    send_byte(pkt1[7]);
    check("w1_word_valid", word_valid, 1);
    check("w1_word", word, 32'h12345678);
    send_byte(8'h2C);
    check("w1_word_pulse", word_valid, 0);
    end_frame();
    check("w1_done", pkt_done, 1);
    check("w1_status", pkt_status, 0);
    tick();

    // bad checksum
    w0 = n_word;
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(pkt1[i]);
    send_byte(8'h2D);
    end_frame();
    check("crc_done", pkt_done, 1);
    check("crc_status", pkt_status, 1);
    check("crc_word_count", n_word - w0, 1);
    tick();

    // frame falls after six bytes
    start_frame();
    for (int i = 0; i < 6; i++) send_byte(pkt1[i]);
    end_frame();
    check("short_done", pkt_done, 1);
    check("short_status", pkt_status, 2);
    tick();

    // extra byte after checksum
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(pkt1[i]);
    send_byte(8'h2C);
    send_byte(8'hAA);
    end_frame();
    check("long_done", pkt_done, 1);
    check("long_status", pkt_status, 3);
    tick();

    // checksum byte coincident with frame falling
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(pkt1[i]);
    data = 8'h2C;
    data_ready = 1'b1;
    frame = 1'b0;
    tick();
    data_ready = 1'b0;
    check("coin_done", pkt_done, 1);
    check("coin_status", pkt_status, 0);
    tick();

    // last payload byte coincident with frame falling
    start_frame();
    for (int i = 0; i < 7; i++) send_byte(pkt1[i]);
    data = 8'h12;
    data_ready = 1'b1;
    frame = 1'b0;
    tick();
    data_ready = 1'b0;
    check("both_word_valid", word_valid, 1);
    check("both_word", word, 32'h12345678);
    check("both_done", pkt_done, 1);
    check("both_status", pkt_status, 2);
    tick();

    // len above MAX_LEN on the small instance
    w0 = n_word_s;
    start_frame();
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h05);
    check("max_hdr_valid", hdr_valid_s, 1);
    check("max_hdr_len", hdr_len_s, 8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    end_frame();
    check("max_done", pkt_done_s, 1);
    check("max_status", pkt_status_s, 3);
    check("max_no_words", n_word_s - w0, 0);
    tick();

    // single-cycle frame with no bytes
    start_frame();
    end_frame();
    check("blip_done", pkt_done, 1);
    check("blip_status", pkt_status, 2);
    tick();

    // reset mid-payload
    d0 = n_done;
    start_frame();
    for (int i = 0; i < 6; i++) send_byte(pkt1[i]);
    reset = 1'b1;
    frame = 1'b0;
    tick();
    check("rst2_done", pkt_done, 0);
    check("rst2_word", word, 0);
    check("rst2_hdr", {hdr_cmd, hdr_dest, hdr_src, hdr_len}, 0);
    check("rst2_status", pkt_status, 0);
    reset = 1'b0;
    tick();
    tick();
    check("rst2_no_done", n_done - d0, 0);

    // clean packet after reset, then a back-to-back packet after a one-cycle gap
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(pkt0[i]);
    send_byte(8'h21);
    end_frame();
    check("post_rst_done", pkt_done, 1);
    check("post_rst_status", pkt_status, 0);
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(pkt1[i]);
    check("b2b_fields", {hdr_cmd, hdr_dest, hdr_src, hdr_len}, 32'h05200001);
    for (int i = 4; i < 8; i++) send_byte(pkt1[i]);
    check("b2b_word", word, 32'h12345678);
    send_byte(8'h2D);
    end_frame();
    check("b2b_done", pkt_done, 1);
    check("b2b_status", pkt_status, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
